fix_field_assembler: RTL and testbench
======================================

// Module: fix_field_assembler
// PURPOSE
//  Downstream of the FIX parser top. Consumes its 32-bit byte stream plus per-lane tag/value
//  valid masks and assembles one complete tag=value field per SOH (0x01). Converts the ASCII
//  decimal tag to binary, packs the value bytes, and emits a one-cycle field record with
//  error status. The field stream feeds the message decoder. There is no backpressure.
// PARAMETERS
//  TAG_W      16  binary tag width; tag > 2**TAG_W-1 is an overflow error
//  MAX_VAL    32  max value bytes per field; field_val_o is MAX_VAL*8 bits
//  CNT_W      32  width of statistics counters
// PORTS
//  clk            in   1            clock
//  rst            in   1            asynchronous, active-high reset
//  data_i         in   32           4 stream bytes; lane0=[7:0] earliest, lane3=[31:24] latest
//  tag_valid_i    in   4            lane n is a tag byte
//  value_valid_i  in   4            lane n is a value byte
//  field_valid_o  out  1            one-cycle pulse: field record valid
//  field_tag_o    out  TAG_W        binary tag
//  field_len_o    out  $clog2(MAX_VAL+1)  value byte count
//  field_val_o    out  MAX_VAL*8    value bytes; byte k at [8k+7:8k]; bytes >= len are 0
//  field_err_o    out  1            record is malformed (qualified by field_valid_o)
//  err_code_o     out  3            1=non-digit tag 2=tag ovf 3=value ovf 4=empty tag/value 5=lane conflict
//  field_cnt_o    out  CNT_W        good fields emitted; wraps
//  err_cnt_o      out  CNT_W        errored fields emitted; wraps
// BEHAVIOUR
//  - Reset: all outputs 0; state=S_TAG; tag accumulator, length and value buffer cleared.
//  - Reset mid-field discards the partial field with no emission.
//  - Lanes are processed in order 0..3 within one cycle; state and accumulators chain lane to lane.
//  - Lane classes:
//    - TAG: tag_valid=1, value_valid=0.
//    - VAL: value_valid=1, tag_valid=0.
//    - SOH: both 0 and byte==8'h01.
//    - CONFLICT: both valid bits = 1.
//    - Any other lane ('=', filler) is ignored.
//  - FSM states: S_TAG (collecting tag), S_VAL (collecting value), S_DROP (error latched).
//    - S_TAG -> S_VAL on the first VAL lane.
//    - Any error -> S_DROP and record the first err_code only; later errors do not overwrite.
//    - SOH from any state -> emit the field, clear accumulators, go to S_TAG.
//  - TAG lane handling:
//    - Byte '0'..'9': tag = tag*10 + digit.
//    - Other byte: err 1.
//    - Result > 2**TAG_W-1: err 2 and tag saturates.
//    - TAG lane while in S_VAL: err 1.
//  - VAL lane handling:
//    - Store the byte at index len, then len++.
//    - Byte arriving when len==MAX_VAL: err 3 and byte dropped.
//  - SOH checks: tag digit count 0 or len 0 -> err 4 (unless an earlier error is already held).
//  - Emission: registered, so field_valid_o pulses the cycle after the word holding SOH.
//    - field_err_o = (err latched).
//    - field_tag_o, field_len_o and field_val_o hold the collected contents.
//    - Lanes after SOH in the same word begin the next field.
//  - Multiple SOHs in one word (only possible on malformed input):
//    - Emit for the lowest-lane SOH with err 4.
//    - Ignore the remainder of the word; next field starts clean.
//  - Counters: field_cnt_o++ on good emission, err_cnt_o++ on errored emission; both wrap.
//  - Record outputs hold their values between pulses; only field_valid_o returns to 0.
// TESTING
//  1. "35=D\x01": data 32'h443D3533 tv=0011 vv=1000, then 32'h00000001 tv=vv=0
//     -> next cycle valid=1 tag=35 len=1 val[7:0]=8'h44 err=0 field_cnt=1.
//  2. Field straddling 3 words with SOH in lane1, new tag "5" in lanes 2-3 of the same word
//     -> one record; second field's tag accumulation continues next word.
//  3. Tag "7A" (byte 8'h41 with tv=1) -> record err=1 code=1; err_cnt=1, field_cnt=0.
//  4. Tag "70000" with TAG_W=16 -> err=1 code=2; value "1"*(MAX_VAL+1) -> err=1 code=3, len=MAX_VAL.
//  5. Lane with tv=vv=1 -> code=5. Then "=X\x01" with no tag digits -> code=4.
//  6. Assert rst mid-value, release, send "8=FIX\x01"
//     -> no record for the aborted field; next record tag=8 len=3 val=24'h584946.

Source files
------------

// File: rtl/fix_field_assembler.sv
// Assembles FIX tag=value fields from a 4-lane byte stream, one record per SOH.
// Lanes chain through the accumulators in order 0..3 within a single cycle.
module fix_field_assembler #(
  parameter int TAG_W   = 16,
  parameter int MAX_VAL = 32,
  parameter int CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    data_i,
  input  logic [3:0]                     tag_valid_i,
  input  logic [3:0]                     value_valid_i,
  output logic                           field_valid_o,
  output logic [TAG_W-1:0]               field_tag_o,
  output logic [$clog2(MAX_VAL+1)-1:0]   field_len_o,
  output logic [MAX_VAL*8-1:0]           field_val_o,
  output logic                           field_err_o,
  output logic [2:0]                     err_code_o,
  output logic [CNT_W-1:0]               field_cnt_o,
  output logic [CNT_W-1:0]               err_cnt_o
);
  localparam int LEN_W = $clog2(MAX_VAL+1);
  localparam logic [TAG_W-1:0] TAG_MAX = '1;

  typedef enum logic [1:0] {S_TAG, S_VAL, S_DROP} state_t;

  state_t               r_state, w_state;
  logic [TAG_W-1:0]     r_tag, w_tag;
  logic                 r_tag_seen, w_tag_seen;
  logic [LEN_W-1:0]     r_len, w_len;
  logic [MAX_VAL*8-1:0] r_val, w_val;
  logic                 r_err, w_err;
  logic [2:0]           r_code, w_code;

  logic                 r_field_valid, r_field_err;
  logic [TAG_W-1:0]     r_field_tag;
  logic [LEN_W-1:0]     r_field_len;
  logic [MAX_VAL*8-1:0] r_field_val;
  logic [2:0]           r_err_code;
  logic [CNT_W-1:0]     r_field_cnt, r_err_cnt;

  logic                 w_emit, w_emit_err, w_stop, w_multi;
  logic [TAG_W-1:0]     w_emit_tag;
  logic [LEN_W-1:0]     w_emit_len;
  logic [MAX_VAL*8-1:0] w_emit_val;
  logic [2:0]           w_emit_code;
  logic [7:0]           w_byte;
  logic [TAG_W+3:0]     w_prod;
  logic [3:0]           w_soh;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_soh[gi] = !tag_valid_i[gi] && !value_valid_i[gi] && (data_i[8*gi +: 8] == 8'h01);
    end
  endgenerate

  // More than one SOH in a word: first one emits as malformed, rest of word dropped
  assign w_multi = (w_soh & (w_soh - 4'd1)) != 4'd0;

  always_comb begin
    w_state     = r_state;
    w_tag       = r_tag;
    w_tag_seen  = r_tag_seen;
    w_len       = r_len;
    w_val       = r_val;
    w_err       = r_err;
    w_code      = r_code;
    w_emit      = 1'b0;
    w_emit_tag  = '0;
    w_emit_len  = '0;
    w_emit_val  = '0;
    w_emit_err  = 1'b0;
    w_emit_code = '0;
    w_stop      = 1'b0;
    w_byte      = '0;
    w_prod      = '0;
    for (int n = 0; n < 4; n++) begin
      w_byte = data_i[8*n +: 8];
      if (w_stop) begin
        w_byte = data_i[8*n +: 8];
      end else if (tag_valid_i[n] && value_valid_i[n]) begin
        if (!w_err) begin
          w_err  = 1'b1;
          w_code = 3'd5;
        end
        w_state = S_DROP;
      end else if (tag_valid_i[n]) begin
        if (w_state == S_TAG) begin
          if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
            w_prod     = (TAG_W+4)'(w_tag) * (TAG_W+4)'(10) + (TAG_W+4)'(w_byte - 8'h30);
            w_tag_seen = 1'b1;
            if (w_prod > (TAG_W+4)'(TAG_MAX)) begin
              w_tag   = TAG_MAX;
              w_err   = 1'b1;
              w_code  = 3'd2;
              w_state = S_DROP;
            end else begin
              w_tag = w_prod[TAG_W-1:0];
            end
          end else begin
            w_err   = 1'b1;
            w_code  = 3'd1;
            w_state = S_DROP;
          end
        end else if (w_state == S_VAL) begin
          w_err   = 1'b1;
          w_code  = 3'd1;
          w_state = S_DROP;
        end
      end else if (value_valid_i[n]) begin
        if (w_state != S_DROP) begin
          if (w_len == LEN_W'(MAX_VAL)) begin
            w_err   = 1'b1;
            w_code  = 3'd3;
            w_state = S_DROP;
          end else begin
            w_val[int'(w_len)*8 +: 8] = w_byte;
            w_len   = w_len + LEN_W'(1);
            w_state = S_VAL;
          end
        end
      end else if (w_byte == 8'h01) begin
        if (!w_err && (w_multi || !w_tag_seen || w_len == '0)) begin
          w_err  = 1'b1;
          w_code = 3'd4;
        end
        w_emit      = 1'b1;
        w_emit_tag  = w_tag;
        w_emit_len  = w_len;
        w_emit_val  = w_val;
        w_emit_err  = w_err;
        w_emit_code = w_code;
        w_state     = S_TAG;
        w_tag       = '0;
        w_tag_seen  = 1'b0;
        w_len       = '0;
        w_val       = '0;
        w_err       = 1'b0;
        w_code      = '0;
        w_stop      = w_multi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_TAG;
      r_tag      <= '0;
      r_tag_seen <= 1'b0;
      r_len      <= '0;
      r_val      <= '0;
      r_err      <= 1'b0;
      r_code     <= '0;
    end else begin
      r_state    <= w_state;
      r_tag      <= w_tag;
      r_tag_seen <= w_tag_seen;
      r_len      <= w_len;
      r_val      <= w_val;
      r_err      <= w_err;
      r_code     <= w_code;
    end
  end

  // Record outputs hold between pulses; only the valid strobe drops back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_field_valid <= 1'b0;
      r_field_tag   <= '0;
      r_field_len   <= '0;
      r_field_val   <= '0;
      r_field_err   <= 1'b0;
      r_err_code    <= '0;
      r_field_cnt   <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_field_valid <= w_emit;
      if (w_emit) begin
        r_field_tag <= w_emit_tag;
        r_field_len <= w_emit_len;
        r_field_val <= w_emit_val;
        r_field_err <= w_emit_err;
        r_err_code  <= w_emit_code;
        if (w_emit_err) r_err_cnt <= r_err_cnt + CNT_W'(1);
        else            r_field_cnt <= r_field_cnt + CNT_W'(1);
      end
    end
  end

  assign field_valid_o = r_field_valid;
  assign field_tag_o   = r_field_tag;
  assign field_len_o   = r_field_len;
  assign field_val_o   = r_field_val;
  assign field_err_o   = r_field_err;
  assign err_code_o    = r_err_code;
  assign field_cnt_o   = r_field_cnt;
  assign err_cnt_o     = r_err_cnt;
endmodule

// File: tb/tb_fix_field_assembler.sv
// Scoreboard bench: a field-level reference model predicts each record; a monitor checks DUT pulses.
module tb_fix_field_assembler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  data_i = '0;
  logic [3:0]   tag_valid_i = '0;
  logic [3:0]   value_valid_i = '0;
  logic         field_valid_o;
  logic [15:0]  field_tag_o;
  logic [5:0]   field_len_o;
  logic [255:0] field_val_o;
  logic         field_err_o;
  logic [2:0]   err_code_o;
  logic [31:0]  field_cnt_o;
  logic [31:0]  err_cnt_o;

  fix_field_assembler #(.TAG_W(16), .MAX_VAL(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .data_i(data_i),
    .tag_valid_i(tag_valid_i), .value_valid_i(value_valid_i),
    .field_valid_o(field_valid_o), .field_tag_o(field_tag_o), .field_len_o(field_len_o),
    .field_val_o(field_val_o), .field_err_o(field_err_o), .err_code_o(err_code_o),
    .field_cnt_o(field_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  tag;
    logic [5:0]   len;
    logic [255:0] val;
    logic         err;
    logic [2:0]   code;
  } rec_t;

  rec_t       exp_q[$];
  int         ev_cls[$];    // 1 tag byte, 2 value byte, 3 conflict
  logic [7:0] ev_byte[$];
  logic [7:0] lb_b[$];
  bit         lb_t[$];
  bit         lb_v[$];
  int n_checks = 0;
  int n_fail   = 0;
  int good_cnt = 0;
  int bad_cnt  = 0;
  int n_rec    = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Judge a whole field from its list of lane events; the first rule broken wins.
  function automatic rec_t eval_field();
    rec_t r;
    int tagv = 0, digits = 0, nval = 0;
    bit in_val = 0;
    r = '0;
    foreach (ev_cls[i]) begin
      if (r.err) break;
      case (ev_cls[i])
        3: begin r.err = 1; r.code = 3'd5; end
        1: begin
          if (in_val || ev_byte[i] < 8'h30 || ev_byte[i] > 8'h39) begin
            r.err = 1; r.code = 3'd1;
          end else begin
            tagv = tagv * 10 + int'(ev_byte[i] - 8'h30);
            digits++;
            if (tagv > 65535) begin tagv = 65535; r.err = 1; r.code = 3'd2; end
          end
        end
        default: begin
          if (nval == 32) begin
            r.err = 1; r.code = 3'd3;
          end else begin
            r.val[nval*8 +: 8] = ev_byte[i];
            nval++;
            in_val = 1;
          end
        end
      endcase
    end
    if (!r.err && (digits == 0 || nval == 0)) begin r.err = 1; r.code = 3'd4; end
    r.tag = tagv[15:0];
    r.len = nval[5:0];
    return r;
  endfunction

  task automatic model_word(input logic [31:0] d, input logic [3:0] tv, input logic [3:0] vv);
    int nsoh = 0;
    rec_t r;
    for (int n = 0; n < 4; n++)
      if (!tv[n] && !vv[n] && d[8*n +: 8] == 8'h01) nsoh++;
    for (int n = 0; n < 4; n++) begin
      if (tv[n] && vv[n]) begin ev_cls.push_back(3); ev_byte.push_back(d[8*n +: 8]); end
      else if (tv[n])     begin ev_cls.push_back(1); ev_byte.push_back(d[8*n +: 8]); end
      else if (vv[n])     begin ev_cls.push_back(2); ev_byte.push_back(d[8*n +: 8]); end
      else if (d[8*n +: 8] == 8'h01) begin
        r = eval_field();
        if (nsoh > 1 && !r.err) begin r.err = 1; r.code = 3'd4; end
        exp_q.push_back(r);
        ev_cls.delete();
        ev_byte.delete();
        if (nsoh > 1) break;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] tv, input logic [3:0] vv);
    @(posedge clk);
    #1;
    data_i = d;
    tag_valid_i = tv;
    value_valid_i = vv;
    model_word(d, tv, vv);
  endtask

  task automatic idle(input int n);
    repeat (n) send_word(32'h0, 4'h0, 4'h0);
  endtask

  task automatic push_lane(input logic [7:0] b, input bit t, input bit v);
    lb_b.push_back(b);
    lb_t.push_back(t);
    lb_v.push_back(v);
  endtask

  task automatic pump();
    logic [31:0] d;
    logic [3:0]  t, v;
    while (lb_b.size() >= 4) begin
      for (int n = 0; n < 4; n++) begin
        d[8*n +: 8] = lb_b.pop_front();
        t[n] = lb_t.pop_front();
        v[n] = lb_v.pop_front();
      end
      send_word(d, t, v);
    end
  endtask

  task automatic flush();
    while (lb_b.size() % 4 != 0) push_lane(8'h00, 0, 0);
    pump();
  endtask

  task automatic push_tag(input string s);
    for (int i = 0; i < s.len(); i++) push_lane(s[i], 1, 0);
  endtask

  task automatic push_val(input string s);
    for (int i = 0; i < s.len(); i++) push_lane(s[i], 0, 1);
  endtask

  task automatic gen_field();
    int k    = $urandom_range(0, 19);
    int ntag = $urandom_range(1, 4);
    int nval = $urandom_range(1, 12);
    if (k == 0) ntag = 0;
    if (k == 1) ntag = 6;
    if (k == 2) nval = 0;
    if (k == 3) nval = $urandom_range(30, 36);
    for (int i = 0; i < ntag; i++) push_lane(8'h30 + 8'($urandom_range(0, 9)), 1, 0);
    if (k == 4) push_lane(8'h41, 1, 0);
    push_lane(8'h3D, 0, 0);
    for (int i = 0; i < nval; i++) begin
      if (k == 5 && i == 0) push_lane(8'($urandom_range(32, 126)), 1, 1);
      else                  push_lane(8'($urandom_range(32, 126)), 0, 1);
    end
    if (k == 6) push_lane(8'h32, 1, 0);
    push_lane(8'h01, 0, 0);
    if (k == 7) push_lane(8'h01, 0, 0);
    if ($urandom_range(0, 3) == 0) push_lane(8'h00, 0, 0);
    pump();
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (!rst && field_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_record: got tag=%0d err=%0b expected no record", field_tag_o, field_err_o);
      end else begin
        e = exp_q.pop_front();
        if (e.err) bad_cnt++;
        else       good_cnt++;
        n_rec++;
        check("rec_err",   256'(field_err_o), 256'(e.err));
        check("rec_code",  256'(err_code_o),  256'(e.code));
        check("rec_tag",   256'(field_tag_o), 256'(e.tag));
        check("rec_len",   256'(field_len_o), 256'(e.len));
        check("rec_val",   field_val_o,       e.val);
        check("field_cnt", 256'(field_cnt_o), 256'(good_cnt));
        check("err_cnt",   256'(err_cnt_o),   256'(bad_cnt));
        $display("rec %0d tag=%0d len=%0d err=%0b code=%0d", n_rec, field_tag_o, field_len_o,
                 field_err_o, err_code_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of stimulus expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    check("rst_valid", 256'(field_valid_o), 256'(0));
    check("rst_tag",   256'(field_tag_o),   256'(0));
    check("rst_val",   field_val_o,         256'(0));
    check("rst_cnt",   256'(field_cnt_o),   256'(0));
    check("rst_ecnt",  256'(err_cnt_o),     256'(0));
    @(posedge clk);
    #3 rst = 1'b0;

    // "35=D" then SOH in its own word
    send_word(32'h443D3533, 4'b0011, 4'b1000);
    send_word(32'h00000001, 4'b0000, 4'b0000);
    idle(2);
    check("t1_tag", 256'(field_tag_o), 256'(35));
    check("t1_val", field_val_o, 256'(8'h44));
    check("t1_cnt", 256'(field_cnt_o), 256'(1));

    // Straddling field, SOH in lane 1, next tag begins in the same word
    push_tag("12"); push_lane(8'h3D, 0, 0); push_val("ABCDEF");
    push_lane(8'h01, 0, 0); push_tag("56"); push_lane(8'h3D, 0, 0); push_val("Z");
    push_lane(8'h01, 0, 0);
    flush();
    idle(2);
    check("t2_tag", 256'(field_tag_o), 256'(56));

    push_tag("7A"); push_lane(8'h3D, 0, 0); push_val("B"); push_lane(8'h01, 0, 0); flush();
    push_tag("70000"); push_lane(8'h3D, 0, 0); push_val("1"); push_lane(8'h01, 0, 0); flush();
    push_tag("1"); push_lane(8'h3D, 0, 0);
    for (int i = 0; i < 33; i++) push_val("1");
    push_lane(8'h01, 0, 0); flush();
    idle(2);
    check("t4_len", 256'(field_len_o), 256'(32));
    check("t4_code", 256'(err_code_o), 256'(3));

    push_tag("9"); push_lane(8'h51, 1, 1); push_val("Q"); push_lane(8'h01, 0, 0);
    push_lane(8'h3D, 0, 0); push_val("X"); push_lane(8'h01, 0, 0); flush();
    idle(2);
    check("t5_code", 256'(err_code_o), 256'(4));

    for (int f = 0; f < 250; f++) begin
      gen_field();
      if ($urandom_range(0, 9) == 0) idle(1);
    end
    flush();
    idle(4);

    // Reset in the middle of a value: partial field vanishes
    push_tag("3"); push_lane(8'h3D, 0, 0); push_val("AB"); pump();
    @(posedge clk);
    #1;
    rst = 1'b1;
    data_i = '0; tag_valid_i = '0; value_valid_i = '0;
    ev_cls.delete(); ev_byte.delete();
    good_cnt = 0; bad_cnt = 0;
    @(negedge clk);
    check("rst2_cnt",  256'(field_cnt_o), 256'(0));
    check("rst2_ecnt", 256'(err_cnt_o),   256'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    push_tag("8"); push_lane(8'h3D, 0, 0); push_val("FIX"); push_lane(8'h01, 0, 0); flush();
    idle(3);
    check("t6_tag", 256'(field_tag_o), 256'(8));
    check("t6_len", 256'(field_len_o), 256'(3));
    check("t6_val", field_val_o, 256'(24'h584946));
    check("t6_cnt", 256'(field_cnt_o), 256'(1));
    check("pending_records", 256'(exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
